systolic_array_os: RTL
======================

# systolic_array_os

Parametrised output-stationary systolic matrix-multiply engine: computes C = A·B for a ROWS×K by K×COLS operand pair, with the accumulators held in a ROWS×COLS grid of signed MAC cells. It is the generalised successor of the fixed 4×4 PE array. It adds:
- internal operand skewing;
- a start/done control FSM;
- valid/ready streaming of operand vectors;
- a back-pressured row-by-row drain of the results.

## Interface
- ROWS, 4, array rows (A-vector lanes, result rows); ≥1
- COLS, 4, array columns (B-vector lanes, result columns); ≥1
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 40, signed accumulator width; ≥2·DATA_WIDTH
- K_WIDTH, 16, width of the reduction-length field
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserting clears all state
- start  input  1  begin a job; sampled only in IDLE
- k_len  input  K_WIDTH  reduction length K, sampled with start
- in_valid  input  1  operand beat valid
- in_ready  output  1  operand beat accepted when in_valid && in_ready
- a_vec  input  ROWS*DATA_WIDTH  column k of A; lane r = bits [r*DATA_WIDTH +: DATA_WIDTH]
- b_vec  input  COLS*DATA_WIDTH  row k of B; lane c likewise
- out_valid  output  1  result row valid
- out_ready  input  1  result row consumed when out_valid && out_ready
- out_row  output  $clog2(ROWS) (min 1)  index of the row on out_data
- out_data  output  COLS*ACC_WIDTH  C[out_row][c] in lane c
- busy  output  1  high in every state but IDLE
- done  output  1  one-cycle pulse after the last row is consumed

## Operation
- **FSM states:** IDLE → LOAD → FLUSH → DRAIN → IDLE.
- **IDLE**
  - On start: latch k_len and clear every accumulator and skew register.
  - Go to LOAD if k_len≠0; go to FLUSH if k_len=0.
- **LOAD**
  - in_ready=1.
  - Each accepted beat increments the beat counter.
  - On the k_len-th accepted beat, go to FLUSH.
  - Cycles with no accepted beat inject zero operands into the skew pipes (a bubble contributes nothing).
- **Skew**
  - A lane r passes through r register stages before entering column 0 of row r.
  - B lane c passes through c stages before entering row 0 of column c.
- **Cell (r,c), each cycle:** acc += sext(a_in·b_in); then a_in is registered right and b_in is registered down.
- **FLUSH**
  - Zero operands are injected for exactly ROWS+COLS-1 cycles, then go to DRAIN.
  - After FLUSH every product of the job has been accumulated.
- **DRAIN**
  - out_valid=1, with out_row and out_data driven from accumulator row out_row, starting at row 0.
  - The row advances on each handshake.
  - The handshake on row ROWS-1 → IDLE, with done=1 in the following cycle.
  - Accumulators are frozen during DRAIN.
- **Arithmetic**
  - Signed DATA_WIDTH×DATA_WIDTH product, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH, with no saturation.
- **Ignored inputs**
  - start is ignored while busy.
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside DRAIN.

## Timing
- **Reset values:** in_ready=0, out_valid=0, out_row=0, out_data=0, busy=0, done=0; FSM in IDLE; accumulators 0.
- **Reset mid-operation:**
  - Takes effect immediately, with no clock needed.
  - The job is discarded.
  - After deassertion the block waits in IDLE for a new start.
- **Start to LOAD:** start accepted at edge T → busy and in_ready high from T+1.
- **Minimum job latency (no stalls):** K cycles of LOAD, then ROWS+COLS-1 cycles of FLUSH, then out_valid at the next cycle.
- **Drain timing:** first row valid at start edge + K + ROWS + COLS cycles. The drain takes ROWS cycles at out_ready=1.
- **out_data stability:** out_data and out_row are registered or derived from frozen state, and are stable while out_valid && !out_ready.
- **k_len=0:** goes through FLUSH and DRAIN normally and outputs all-zero rows.
- **Back-to-back jobs:** start asserted in the cycle done is high is accepted (the FSM is already in IDLE).

## Test plan
- **Identity × B, 4×4, K=4:** stream A=I and B=[[1..4],[5..8],[9..12],[13..16]] with in_valid continuous and out_ready=1 → rows read back equal B exactly; done pulses once.
- **All-ones, K=8 with stalls:** randomly drop in_valid (about 30% of cycles) → every C element = 8; the count of in_ready cycles ≥ 8 and exactly 8 beats are accepted.
- **Signed, K=4:** all a=-3, all b=5 → every element = -60 (0xFF_FFFF_FFC4 at ACC_WIDTH=40). Then a=-32768, b=-32768, K=2 → 0x00_8000_0000.
- **Drain back-pressure:** hold out_ready=0 for 5 cycles on row 1 → out_row stays 1 and out_data is unchanged; rows arrive in order 0..3 with none lost or repeated; done is asserted only after row 3 is consumed.
- **Edge cases:** k_len=0 → four all-zero rows, then done. start pulsed during LOAD → ignored, and the result is unaffected.
- **Reset during LOAD** (after 2 of 6 beats): all outputs go to 0 immediately. A subsequent job with K=3 and all-ones operands → every element = 3, with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_array_os.sv
// Output-stationary systolic matrix multiplier: C = A*B over a ROWS x COLS grid of
// signed MAC cells, with operand skewing, streaming load and a back-pressured row drain.
module systolic_array_os #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [K_WIDTH-1:0]                    k_len,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]            a_vec,
  input  logic [COLS*DATA_WIDTH-1:0]            b_vec,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [COLS*ACC_WIDTH-1:0]             out_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_W  = $clog2(ROWS + COLS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [FL_W-1:0]    FLUSH_LAST = FL_W'(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

  logic [1:0]         state;
  logic [K_WIDTH-1:0] k_reg;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [FL_W-1:0]    flush_cnt;
  logic [ROW_W-1:0]   row_idx;

  logic clear;
  logic accept;
  logic run;

  logic [DATA_WIDTH-1:0]        a_west  [ROWS];
  logic [DATA_WIDTH-1:0]        b_north [COLS];
  logic [DATA_WIDTH-1:0]        a_east  [ROWS][COLS];
  logic [DATA_WIDTH-1:0]        b_south [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc     [ROWS][COLS];

  assign clear  = (state == S_IDLE) && start;
  assign accept = (state == S_LOAD) && in_valid;
  assign run    = (state == S_LOAD) || (state == S_FLUSH);

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign out_row   = row_idx;

  // Control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_reg     <= k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            state     <= (k_len != '0) ? S_LOAD : S_FLUSH;
          end
        end
        S_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + K_ONE;
            if (beat_cnt == k_reg - K_ONE) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= S_DRAIN;
          else flush_cnt <= flush_cnt + FL_W'(1);
        end
        default: begin
          if (out_ready) begin
            if (row_idx == ROW_LAST) begin
              state   <= S_IDLE;
              row_idx <= '0;
              done    <= 1'b1;
            end else begin
              row_idx <= row_idx + ROW_W'(1);
            end
          end
        end
      endcase
    end
  end

  // A skew: lane r is delayed r cycles so it meets its B partner at cell (r,c) on time
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [DATA_WIDTH-1:0] inj;
    assign inj = accept ? a_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_west[r] = inj;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] pipe [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe <= '{default: '0};
        end else if (clear) begin
          pipe <= '{default: '0};
        end else begin
          pipe[0] <= inj;
          for (int unsigned s = 1; s < r; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign a_west[r] = pipe[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic [DATA_WIDTH-1:0] inj;
    assign inj = accept ? b_vec[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_north[c] = inj;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] pipe [c];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe <= '{default: '0};
        end else if (clear) begin
          pipe <= '{default: '0};
        end else begin
          pipe[0] <= inj;
          for (int unsigned s = 1; s < c; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign b_north[c] = pipe[c-1];
    end
  end

  // MAC grid: A flows east, B flows south, sums stay put
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_WIDTH-1:0]         a_in;
      logic [DATA_WIDTH-1:0]         b_in;
      logic [DATA_WIDTH-1:0]         a_q;
      logic [DATA_WIDTH-1:0]         b_q;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]   acc_q;

      if (c == 0) begin : g_aw
        assign a_in = a_west[r];
      end else begin : g_an
        assign a_in = a_east[r][c-1];
      end
      if (r == 0) begin : g_bn
        assign b_in = b_north[c];
      end else begin : g_bs
        assign b_in = b_south[r-1][c];
      end

      assign prod = $signed(a_in) * $signed(b_in);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (clear) begin
          acc_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (run) begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
          a_q   <= a_in;
          b_q   <= b_in;
        end
      end

      assign a_east[r][c]  = a_q;
      assign b_south[r][c] = b_q;
      assign acc[r][c]     = acc_q;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == S_DRAIN) begin
      for (int unsigned c = 0; c < COLS; c++)
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][c];
    end
  end

endmodule
